// File: rtl/execute_stage.sv
// Execute stage: operand select/forward, 4x32 SIMD ALU, lane rerouting, branch/jump resolve.
// Latency 1 cycle (outputs double as the E->M register); no backpressure, one op accepted per cycle.
module execute_stage (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         select_operand_0_vector_E,
  input  logic         select_operand_1_vector_E,
  input  logic [1:0]   forward_operand_0_E,
  input  logic [1:0]   forward_operand_1_E,
  input  logic [2:0]   cond_code_E,
  input  logic         branch_E,
  input  logic         jump_E,
  input  logic         i_jump_E,
  input  logic         PC_to_ALU_E,
  input  logic         ALU_source_E,
  input  logic [3:0]   ALU_op_E,
  input  logic [2:0]   rerouting_code_E,
  input  logic         rerouting_select_E,
  input  logic [31:0]  scalar_reg_data_0_E,
  input  logic [31:0]  scalar_reg_data_1_E,
  input  logic [127:0] vector_reg_data_0_E,
  input  logic [127:0] vector_reg_data_1_E,
  input  logic [31:0]  PC_E,
  input  logic [31:0]  immediate_E,
  input  logic [127:0] data_bus_M,
  input  logic [127:0] data_bus_W,
  output logic [127:0] ALU_result_bus_E,
  output logic [127:0] write_data_bus_E,
  output logic [1:0]   PC_source_E,
  output logic         change_PC_E
);

  logic [127:0]      reg_op_0, reg_op_1, fwd_0, fwd_1, alu_a, alu_b;
  logic [3:0][31:0]  alu_lanes, route_lanes;
  logic [1:0]        bcast_idx;
  logic              cond_true, change_pc_nxt;
  logic [1:0]        pc_src_nxt;

  function automatic logic [127:0] forward_sel(input logic [1:0] sel, input logic [127:0] reg_val,
                                               input logic [127:0] m_val, input logic [127:0] w_val);
    logic [127:0] r;
    case (sel)
      2'b01:   r = w_val;
      2'b10:   r = m_val;
      default: r = reg_val;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] alu_lane(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a & b;
      4'd3:    r = a | b;
      4'd4:    r = a ^ b;
      4'd5:    r = a << b[4:0];
      4'd6:    r = a >> b[4:0];
      4'd7:    r = $unsigned($signed(a) >>> b[4:0]);
      4'd8:    r = {31'b0, $signed(a) < $signed(b)};
      4'd9:    r = {31'b0, a < b};
      4'd10:   r = b;
      4'd11:   r = a * b;
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    reg_op_0 = select_operand_0_vector_E ? vector_reg_data_0_E : {96'b0, scalar_reg_data_0_E};
    reg_op_1 = select_operand_1_vector_E ? vector_reg_data_1_E : {96'b0, scalar_reg_data_1_E};
    fwd_0    = forward_sel(forward_operand_0_E, reg_op_0, data_bus_M, data_bus_W);
    fwd_1    = forward_sel(forward_operand_1_E, reg_op_1, data_bus_M, data_bus_W);
    alu_a    = PC_to_ALU_E  ? {96'b0, PC_E}    : fwd_0;
    alu_b    = ALU_source_E ? {4{immediate_E}} : fwd_1;
  end

  // One ALU per lane; no carry crosses a 32-bit boundary.
  always_comb begin
    alu_lanes = '0;
    for (int i = 0; i < 4; i++) begin
      alu_lanes[i] = alu_lane(ALU_op_E, alu_a[32*i +: 32], alu_b[32*i +: 32]);
    end
  end

  always_comb begin
    route_lanes = alu_lanes;
    bcast_idx   = 2'(rerouting_code_E - 3'd1);
    if (rerouting_select_E) begin
      case (rerouting_code_E)
        3'd1, 3'd2, 3'd3, 3'd4: route_lanes = {4{alu_lanes[bcast_idx]}};
        3'd5: for (int i = 0; i < 4; i++) route_lanes[i] = alu_lanes[2'(3 - i)];
        3'd6: for (int i = 0; i < 4; i++) route_lanes[i] = alu_lanes[2'(i + 3)];
        3'd7: begin
          route_lanes    = '0;
          route_lanes[0] = alu_lanes[0] + alu_lanes[1] + alu_lanes[2] + alu_lanes[3];
        end
        default: route_lanes = alu_lanes;
      endcase
    end
  end

  // Branch compare always sees the forwarded registers, never PC or immediate.
  always_comb begin
    case (cond_code_E)
      3'b000:  cond_true = fwd_0[31:0] == fwd_1[31:0];
      3'b001:  cond_true = fwd_0[31:0] != fwd_1[31:0];
      3'b100:  cond_true = $signed(fwd_0[31:0]) <  $signed(fwd_1[31:0]);
      3'b101:  cond_true = $signed(fwd_0[31:0]) >= $signed(fwd_1[31:0]);
      3'b110:  cond_true = fwd_0[31:0] <  fwd_1[31:0];
      3'b111:  cond_true = fwd_0[31:0] >= fwd_1[31:0];
      default: cond_true = 1'b0;
    endcase
    change_pc_nxt = (branch_E & cond_true) | jump_E | i_jump_E;
    if (i_jump_E)                           pc_src_nxt = 2'b10;
    else if (jump_E | (branch_E & cond_true)) pc_src_nxt = 2'b01;
    else                                    pc_src_nxt = 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ALU_result_bus_E <= '0;
      write_data_bus_E <= '0;
      PC_source_E      <= 2'b00;
      change_PC_E      <= 1'b0;
    end else begin
      ALU_result_bus_E <= route_lanes;
      write_data_bus_E <= fwd_1;
      PC_source_E      <= pc_src_nxt;
      change_PC_E      <= change_pc_nxt;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed cases with hand-derived results plus random ops
// checked against a lane-array reference model.
module tb_execute_stage;

  logic         clk;
  logic         rst_n;
  logic         vs0, vs1, br, jmp, ijmp, pca, asrc, rsel;
  logic [1:0]   fw0, fw1;
  logic [2:0]   cc, rcode;
  logic [3:0]   op;
  logic [31:0]  s0, s1, pc, imm;
  logic [127:0] v0, v1, dm, dw;
  logic [127:0] res_o, wd_o;
  logic [1:0]   src_o;
  logic         chg_o;

  typedef struct {
    bit rst; bit vs0; bit vs1; bit [1:0] f0; bit [1:0] f1; bit [2:0] cc;
    bit br; bit j; bit ij; bit pca; bit asrc; bit [3:0] op; bit [2:0] rc; bit rs;
    bit [31:0] s0; bit [31:0] s1; bit [31:0] pc; bit [31:0] imm;
    bit [127:0] v0; bit [127:0] v1; bit [127:0] dm; bit [127:0] dw;
  } stim_t;

  typedef struct {
    bit [127:0] res; bit [127:0] wd; bit [1:0] src; bit chg; string name;
  } exp_t;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n),
    .select_operand_0_vector_E(vs0), .select_operand_1_vector_E(vs1),
    .forward_operand_0_E(fw0), .forward_operand_1_E(fw1),
    .cond_code_E(cc), .branch_E(br), .jump_E(jmp), .i_jump_E(ijmp),
    .PC_to_ALU_E(pca), .ALU_source_E(asrc), .ALU_op_E(op),
    .rerouting_code_E(rcode), .rerouting_select_E(rsel),
    .scalar_reg_data_0_E(s0), .scalar_reg_data_1_E(s1),
    .vector_reg_data_0_E(v0), .vector_reg_data_1_E(v1),
    .PC_E(pc), .immediate_E(imm), .data_bus_M(dm), .data_bus_W(dw),
    .ALU_result_bus_E(res_o), .write_data_bus_E(wd_o),
    .PC_source_E(src_o), .change_PC_E(chg_o)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic stim_t blank();
    stim_t s;
    s = '{default: 0};
    s.rst = 1'b0;
    return s;
  endfunction

  function automatic bit [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: operate on lanes as plain unsigned numbers.
  function automatic exp_t model(stim_t s, string name);
    exp_t e;
    bit [127:0] r0, r1, f0, f1;
    bit [31:0] a [4]; bit [31:0] b [4]; bit [31:0] r [4]; bit [31:0] o [4];
    longint unsigned prod, sum;
    int signed sa;
    bit taken;
    e.name = name;
    if (s.rst) begin
      e.res = 0; e.wd = 0; e.src = 0; e.chg = 0;
      return e;
    end
    r0 = s.vs0 ? s.v0 : 128'(s.s0);
    r1 = s.vs1 ? s.v1 : 128'(s.s1);
    f0 = (s.f0 == 2'd1) ? s.dw : (s.f0 == 2'd2) ? s.dm : r0;
    f1 = (s.f1 == 2'd1) ? s.dw : (s.f1 == 2'd2) ? s.dm : r1;
    for (int i = 0; i < 4; i++) begin
      a[i] = s.pca ? ((i == 0) ? s.pc : 32'd0) : f0[32*i +: 32];
      b[i] = s.asrc ? s.imm : f1[32*i +: 32];
      sa = int'(a[i]);
      case (s.op)
        0: r[i] = a[i] + b[i];
        1: r[i] = a[i] - b[i];
        2: r[i] = a[i] & b[i];
        3: r[i] = a[i] | b[i];
        4: r[i] = a[i] ^ b[i];
        5: r[i] = a[i] << (b[i] % 32);
        6: r[i] = a[i] >> (b[i] % 32);
        7: r[i] = 32'(sa >>> (b[i] % 32));
        8: r[i] = (int'(a[i]) < int'(b[i])) ? 32'd1 : 32'd0;
        9: r[i] = (a[i] < b[i]) ? 32'd1 : 32'd0;
        10: r[i] = b[i];
        11: begin prod = longint'(a[i]) * longint'(b[i]); r[i] = prod[31:0]; end
        default: r[i] = 0;
      endcase
    end
    o = r;
    if (s.rs) begin
      case (s.rc)
        1, 2, 3, 4: for (int i = 0; i < 4; i++) o[i] = r[s.rc - 1];
        5: for (int i = 0; i < 4; i++) o[i] = r[3 - i];
        6: for (int i = 0; i < 4; i++) o[i] = r[(i + 3) % 4];
        7: begin
          sum = 0;
          for (int i = 0; i < 4; i++) sum += r[i];
          o[0] = sum[31:0]; o[1] = 0; o[2] = 0; o[3] = 0;
        end
        default: ;
      endcase
    end
    e.res = {o[3], o[2], o[1], o[0]};
    e.wd  = f1;
    case (s.cc)
      3'b000: taken = f0[31:0] == f1[31:0];
      3'b001: taken = f0[31:0] != f1[31:0];
      3'b100: taken = int'(f0[31:0]) <  int'(f1[31:0]);
      3'b101: taken = int'(f0[31:0]) >= int'(f1[31:0]);
      3'b110: taken = f0[31:0] <  f1[31:0];
      3'b111: taken = f0[31:0] >= f1[31:0];
      default: taken = 0;
    endcase
    taken = taken & s.br;
    e.chg = taken | s.j | s.ij;
    e.src = s.ij ? 2'b10 : (s.j | taken) ? 2'b01 : 2'b00;
    return e;
  endfunction

  task automatic drive(stim_t s);
    @(negedge clk);
    rst_n = ~s.rst; vs0 = s.vs0; vs1 = s.vs1; fw0 = s.f0; fw1 = s.f1; cc = s.cc;
    br = s.br; jmp = s.j; ijmp = s.ij; pca = s.pca; asrc = s.asrc; op = s.op;
    rcode = s.rc; rsel = s.rs; s0 = s.s0; s1 = s.s1; pc = s.pc; imm = s.imm;
    v0 = s.v0; v1 = s.v1; dm = s.dm; dw = s.dw;
  endtask

  task automatic issue_exp(stim_t s, bit [127:0] res, bit [127:0] wd, bit [1:0] src, bit chg, string name);
    exp_t e;
    drive(s);
    e.res = res; e.wd = wd; e.src = src; e.chg = chg; e.name = name;
    expq.push_back(e);
  endtask

  task automatic issue_model(stim_t s, string name);
    drive(s);
    expq.push_back(model(s, name));
  endtask

  task automatic check(string name, bit [127:0] act, bit [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: every cycle the registered outputs correspond to the oldest issued op.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check({e.name, ".result"}, res_o, e.res);
        check({e.name, ".wdata"},  wd_o,  e.wd);
        check({e.name, ".pcsrc"},  128'(src_o), 128'(e.src));
        check({e.name, ".chg"},    128'(chg_o), 128'(e.chg));
      end
    end
  end

  initial begin
    stim_t s;
    bit [127:0] vec;
    rst_n = 0; vs0 = 0; vs1 = 0; fw0 = 0; fw1 = 0; cc = 0; br = 0; jmp = 0; ijmp = 0;
    pca = 0; asrc = 0; op = 0; rcode = 0; rsel = 0; s0 = 0; s1 = 0; pc = 0; imm = 0;
    v0 = 0; v1 = 0; dm = 0; dw = 0;

    for (int k = 0; k < 3; k++) begin
      s = blank(); s.rst = 1; s.vs0 = 1; s.vs1 = 1; s.v0 = rand128(); s.v1 = rand128();
      s.op = 4'(k); s.j = 1; s.ij = 1; s.f1 = 2'd2; s.dm = rand128();
      issue_exp(s, 0, 0, 0, 0, "reset");
    end

    vec = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    s = blank(); s.vs0 = 1; s.vs1 = 1; s.v0 = vec; s.v1 = vec;
    issue_exp(s, 128'h22224444_66668888_AAAACCCC_EEEF1110, vec, 0, 0, "vec_add");

    s = blank(); s.f0 = 2'd2; s.dm = 128'd5; s.f1 = 2'd1; s.dw = 128'd3; s.op = 1;
    issue_exp(s, 128'd2, 128'd3, 0, 0, "fwd_sub");

    s = blank(); s.vs0 = 1; s.v0 = 128'h00000004_00000003_00000002_00000001;
    s.asrc = 1; s.imm = 1; s.rs = 1; s.rc = 7;
    issue_exp(s, 128'd14, 0, 0, 0, "reroute_sum");
    s.rc = 5;
    issue_exp(s, 128'h00000002_00000003_00000004_00000005, 0, 0, 0, "reroute_rev");

    s = blank(); s.s0 = 7; s.s1 = 7; s.br = 1; s.cc = 3'b000;
    issue_exp(s, 128'd14, 128'd7, 2'b01, 1, "beq_taken");
    s.cc = 3'b001;
    issue_exp(s, 128'd14, 128'd7, 2'b00, 0, "bne_not");
    s.s0 = 32'hFFFF_FFFF; s.s1 = 0; s.cc = 3'b100;
    issue_exp(s, 128'hFFFF_FFFF, 0, 2'b01, 1, "blt_taken");
    s.cc = 3'b110;
    issue_exp(s, 128'hFFFF_FFFF, 0, 2'b00, 0, "bltu_not");

    s = blank(); s.ij = 1; s.j = 1; s.op = 12; s.s0 = 9; s.s1 = 4;
    issue_exp(s, 0, 128'd4, 2'b10, 1, "jalr");
    s.ij = 0; s.op = 15;
    issue_exp(s, 0, 128'd4, 2'b01, 1, "jal");

    for (int k = 0; k < 300; k++) begin
      s = blank();
      s.rst = ($urandom_range(0, 19) == 0);
      s.vs0 = 1'($urandom); s.vs1 = 1'($urandom);
      s.f0 = 2'($urandom); s.f1 = 2'($urandom); s.cc = 3'($urandom);
      s.br = 1'($urandom); s.j = ($urandom_range(0, 5) == 0); s.ij = ($urandom_range(0, 5) == 0);
      s.pca = ($urandom_range(0, 3) == 0); s.asrc = ($urandom_range(0, 2) == 0);
      s.op = 4'($urandom); s.rc = 3'($urandom); s.rs = 1'($urandom);
      s.s0 = $urandom; s.s1 = ($urandom_range(0, 3) == 0) ? s.s0 : $urandom;
      s.pc = $urandom; s.imm = $urandom;
      s.v0 = rand128(); s.v1 = rand128(); s.dm = rand128(); s.dw = rand128();
      issue_model(s, "rand");
    end

    for (int k = 0; k < 20 && expq.size() > 0; k++) @(negedge clk);
    if (expq.size() > 0) begin
      total++; bad++;
      $display("FAIL drain: %0d results still pending, want 0", expq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
